// File: rtl/bf_search_controller_if.sv
// Lane bus between the search controller and its bank of brute-force
// generator lanes. The controller uses the master modport and the
// generators use the slave modport.
interface bf_search_controller_if #(
  parameter int N_LANES = 4
);
  logic [N_LANES-1:0]     lane_valid;
  logic [N_LANES*128-1:0] lane_password;
  logic [N_LANES-1:0]     lane_ready;
  logic                   lane_enable;
  logic [N_LANES*8-1:0]   lane_start_pos;
  logic [2:0]             lane_increment;

  modport master (
    input  lane_valid, lane_password,
    output lane_ready, lane_enable, lane_start_pos, lane_increment
  );

  modport slave (
    output lane_valid, lane_password,
    input  lane_ready, lane_enable, lane_start_pos, lane_increment
  );
endinterface

// File: rtl/bf_search_controller.sv
// Brute-force search controller: configures N_LANES generator lanes,
// round-robin accepts one candidate per cycle, compares it against the
// loaded target through a one-cycle compare stage and reports
// found / exhausted status.
// Optional feature: define BF_STALL_COUNT_EN to add the stall_cycles output.
module bf_search_controller #(
  parameter int          N_LANES      = 4,
  parameter logic [7:0]  CHAR_BASE    = 8'h61,
  parameter logic [31:0] MAX_ATTEMPTS = 32'hFFFF_FFFF,
  parameter int          LANE_W       = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [127:0]         target,
  input  logic [4:0]           target_len,
  bf_search_controller_if.master lanes,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted,
  output logic [127:0]         match_password,
  output logic [LANE_W-1:0]    match_lane,
  output logic [31:0]          attempts
`ifdef BF_STALL_COUNT_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_RUN       = 3'd2;
  localparam logic [2:0] S_FOUND     = 3'd3;
  localparam logic [2:0] S_EXHAUSTED = 3'd4;

  logic [2:0]             state;
  logic [127:0]           target_q;
  logic [4:0]             len_q;
  logic [4:0]             eff_len;
  logic [LANE_W-1:0]      rr_ptr;
  logic [LANE_W-1:0]      next_ptr;
  logic                   cmp_valid;
  logic [127:0]           cmp_password;
  logic [LANE_W-1:0]      cmp_lane;
  logic                   cmp_match;
  logic                   limit_hit;
  logic                   do_load;
  logic [2*N_LANES-1:0]   valid_dbl;
  logic [N_LANES-1:0]     valid_rot;
  logic [LANE_W:0]        pos_sum;
  logic [N_LANES-1:0]     grant;
  logic                   grant_any;
  logic [LANE_W-1:0]      grant_idx;
  logic [127:0]           grant_password;
  logic [127:0]           len_mask;

  // Each lane starts one character further into the alphabet and all lanes step by N_LANES.
  for (genvar i = 0; i < N_LANES; i++) begin : g_start_pos
    assign lanes.lane_start_pos[8*i +: 8] = CHAR_BASE + 8'(i);
  end

  assign lanes.lane_increment = 3'(N_LANES);
  assign lanes.lane_enable    = (state == S_RUN);
  assign lanes.lane_ready     = grant;
  assign busy                 = (state == S_LOAD) || (state == S_RUN);
  assign do_load              = start && !abort &&
                                ((state == S_IDLE) || (state == S_FOUND) || (state == S_EXHAUSTED));
  assign cmp_match            = cmp_valid && (((cmp_password ^ target_q) & len_mask) == '0);
  assign limit_hit            = (attempts + 32'd1) == MAX_ATTEMPTS;
  assign next_ptr             = (grant_idx == LANE_W'(N_LANES - 1)) ? '0 : grant_idx + 1'b1;

  // Clamp the requested length into the 1..16 character range.
  always_comb begin
    eff_len = target_len;
    if (target_len == 5'd0) eff_len = 5'd1;
    else if (target_len > 5'd16) eff_len = 5'd16;
  end

  // Only the low len_q bytes take part in the comparison.
  always_comb begin
    len_mask = '0;
    for (int b = 0; b < 16; b++) begin
      len_mask[8*b +: 8] = (5'(b) < len_q) ? 8'hFF : 8'h00;
    end
  end

  // Round-robin grant: rotate valids so the pointer lane is bit 0, take the first set bit.
  always_comb begin
    grant          = '0;
    grant_any      = 1'b0;
    grant_idx      = '0;
    grant_password = '0;
    pos_sum        = '0;
    valid_dbl      = {lanes.lane_valid, lanes.lane_valid} >> rr_ptr;
    valid_rot      = valid_dbl[N_LANES-1:0];
    if (state == S_RUN && !abort) begin
      for (int k = 0; k < N_LANES; k++) begin
        if (!grant_any && valid_rot[k]) begin
          grant_any = 1'b1;
          pos_sum   = {1'b0, rr_ptr} + (LANE_W+1)'(k);
          if (pos_sum >= (LANE_W+1)'(N_LANES)) pos_sum = pos_sum - (LANE_W+1)'(N_LANES);
          grant_idx = pos_sum[LANE_W-1:0];
        end
      end
      for (int i = 0; i < N_LANES; i++) begin
        if (grant_any && grant_idx == LANE_W'(i)) begin
          grant[i]       = 1'b1;
          grant_password = lanes.lane_password[128*i +: 128];
        end
      end
    end
  end

  // Main search sequencer: state, compare stage, counters and match capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      target_q       <= '0;
      len_q          <= 5'd1;
      rr_ptr         <= '0;
      cmp_valid      <= 1'b0;
      cmp_password   <= '0;
      cmp_lane       <= '0;
      found          <= 1'b0;
      exhausted      <= 1'b0;
      match_password <= '0;
      match_lane     <= '0;
      attempts       <= '0;
    end else if (abort) begin
      state     <= S_IDLE;
      found     <= 1'b0;
      exhausted <= 1'b0;
      cmp_valid <= 1'b0;
    end else if (do_load) begin
      state          <= S_LOAD;
      target_q       <= target;
      len_q          <= eff_len;
      rr_ptr         <= '0;
      cmp_valid      <= 1'b0;
      found          <= 1'b0;
      exhausted      <= 1'b0;
      match_password <= '0;
      match_lane     <= '0;
      attempts       <= '0;
    end else begin
      case (state)
        S_LOAD: state <= S_RUN;
        S_RUN: begin
          cmp_valid    <= grant_any;
          cmp_password <= grant_password;
          cmp_lane     <= grant_idx;
          if (grant_any) rr_ptr <= next_ptr;
          if (cmp_valid) begin
            attempts <= attempts + 32'd1;
            if (cmp_match) begin
              found          <= 1'b1;
              match_password <= cmp_password;
              match_lane     <= cmp_lane;
              cmp_valid      <= 1'b0;
              state          <= S_FOUND;
            end else if (limit_hit) begin
              exhausted <= 1'b1;
              cmp_valid <= 1'b0;
              state     <= S_EXHAUSTED;
            end
          end
        end
        default: cmp_valid <= 1'b0;
      endcase
    end
  end

`ifdef BF_STALL_COUNT_EN
  // Saturating count of RUN cycles where no lane could be granted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (do_load || state == S_LOAD) begin
      stall_cycles <= '0;
    end else if (state == S_RUN && !grant_any && stall_cycles != 32'hFFFF_FFFF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
